// File: rtl/program_loader_pkg.sv
// Shared instruction-set and loader definitions. The instruction decoder and
// the program loader both import this package.
package program_loader_pkg;

    // Instruction word geometry: 8-bit data/immediate field plus 5-bit opcode.
    localparam int PM_ID_INS_WIDTH = 13;
    localparam int OPCODE_WIDTH    = 5;

    // Opcode section held in Ins[12:11]; the "rest" section carries loads/stores.
    localparam logic [1:0] SEC_REST = 2'b11;

    // Rest-section opcode codes in Ins[10:8]; only these five are implemented.
    localparam logic [2:0] REST_LD_R   = 3'd0;
    localparam logic [2:0] REST_LD_DM  = 3'd1;
    localparam logic [2:0] REST_LD_IMD = 3'd2;
    localparam logic [2:0] REST_ST_R   = 3'd3;
    localparam logic [2:0] REST_ST_DM  = 3'd4;

    // Loader state encoding.
    typedef enum logic [2:0] {
        LS_IDLE  = 3'd0,
        LS_LO    = 3'd1,
        LS_HI    = 3'd2,
        LS_WRITE = 3'd3,
        LS_ERROR = 3'd4
    } loader_state_e;

    // True when the 5-bit opcode names an implemented instruction.
    function automatic logic opcode_is_legal(input logic [OPCODE_WIDTH-1:0] opcode);
        logic legal_s;
        if (opcode[4:3] == SEC_REST) begin
            case (opcode[2:0])
                REST_LD_R, REST_LD_DM, REST_LD_IMD, REST_ST_R, REST_ST_DM: legal_s = 1'b1;
                default:                                                  legal_s = 1'b0;
            endcase
        end else begin
            legal_s = 1'b1;
        end
        return legal_s;
    endfunction

endpackage

// File: rtl/program_loader_ins_checker.sv
// Combinational legality check of one assembled instruction word. The word is
// passed through unchanged so the write path takes word and verdict together.
module ins_checker
    import program_loader_pkg::*;
(
    input  logic [PM_ID_INS_WIDTH-1:0] ins,
    output logic                       legal,
    output logic [PM_ID_INS_WIDTH-1:0] checked_word
);

    // Decode the opcode field and forward the word alongside its verdict.
    always_comb begin
        legal        = opcode_is_legal(ins[PM_ID_INS_WIDTH-1:8]);
        checked_word = ins;
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles little-endian byte pairs from a valid/ready stream
// into 13-bit instruction words, rejects illegal encodings, and writes legal
// words to consecutive program-memory addresses while holding the CPU busy.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PM_AW    = 8,
    parameter int InsWidth = PM_ID_INS_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic [PM_AW:0]      Len,
    input  logic                In_Valid,
    input  logic [7:0]          In_Byte,
    output logic                In_Ready,
    output logic                PM_WE,
    output logic [PM_AW-1:0]    PM_Addr,
    output logic [InsWidth-1:0] PM_WData,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic [PM_AW-1:0]    ErrAddr
);

    localparam logic [PM_AW:0]   LEN_ONE = {{PM_AW{1'b0}}, 1'b1};
    localparam logic [PM_AW-1:0] CNT_ONE = {{(PM_AW-1){1'b0}}, 1'b1};

    loader_state_e               state_r;
    loader_state_e               state_s;

    logic [PM_AW-1:0]            counter_r;
    logic [PM_AW:0]              len_r;
    logic [7:0]                  lo_r;
    logic [PM_AW-1:0]            pm_addr_r;
    logic [InsWidth-1:0]         pm_wdata_r;
    logic                        done_r;
    logic                        err_r;
    logic [PM_AW-1:0]            err_addr_r;

    logic                        in_ready_s;
    logic                        busy_s;
    logic                        pm_we_s;

    logic                        start_acc_s;
    logic                        len_zero_s;
    logic                        accept_s;
    logic                        lo_accept_s;
    logic                        hi_accept_s;
    logic                        pad_clear_s;
    logic                        chk_legal_s;
    logic                        word_legal_s;
    logic                        last_word_s;
    logic [PM_ID_INS_WIDTH-1:0]  word_s;
    logic [PM_ID_INS_WIDTH-1:0]  checked_word_s;

    // A Start is only honoured while no load is running.
    assign start_acc_s  = Start && ((state_r == LS_IDLE) || (state_r == LS_ERROR));
    assign len_zero_s   = (Len == '0);
    assign accept_s     = In_Valid && in_ready_s;
    assign lo_accept_s  = accept_s && (state_r == LS_LO);
    assign hi_accept_s  = accept_s && (state_r == LS_HI);

    // High byte carries the opcode in [4:0]; its top three bits must be clear.
    assign pad_clear_s  = (In_Byte[7:5] == 3'b000);
    assign word_s       = {In_Byte[4:0], lo_r};
    assign word_legal_s = pad_clear_s && chk_legal_s;

    // Counter is compared one-wider so a full-depth load ends at the top address.
    assign last_word_s  = ({1'b0, counter_r} == (len_r - LEN_ONE));

    ins_checker u_ins_checker (
        .ins          (word_s),
        .legal        (chk_legal_s),
        .checked_word (checked_word_s)
    );

    // State register; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LS_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LS_IDLE, LS_ERROR: begin
                if (start_acc_s && !len_zero_s) begin
                    state_s = LS_LO;
                end else if (start_acc_s) begin
                    state_s = LS_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            LS_LO: begin
                if (accept_s) begin
                    state_s = LS_HI;
                end else begin
                    state_s = LS_LO;
                end
            end
            LS_HI: begin
                if (accept_s && word_legal_s) begin
                    state_s = LS_WRITE;
                end else if (accept_s) begin
                    state_s = LS_ERROR;
                end else begin
                    state_s = LS_HI;
                end
            end
            LS_WRITE: begin
                if (last_word_s) begin
                    state_s = LS_IDLE;
                end else begin
                    state_s = LS_LO;
                end
            end
            default: begin
                state_s = LS_IDLE;
            end
        endcase
    end

    // Handshake, busy and write-enable decoded from the current state.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        pm_we_s    = 1'b0;
        case (state_r)
            LS_LO, LS_HI: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            LS_WRITE: begin
                busy_s  = 1'b1;
                pm_we_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
                pm_we_s    = 1'b0;
            end
        endcase
    end

    // Load parameters, word assembly, write port and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_r  <= '0;
            len_r      <= '0;
            lo_r       <= '0;
            pm_addr_r  <= '0;
            pm_wdata_r <= '0;
        end else begin
            if (start_acc_s) begin
                len_r     <= Len;
                counter_r <= '0;
            end else if ((state_r == LS_WRITE) && !last_word_s) begin
                counter_r <= counter_r + CNT_ONE;
            end else begin
                counter_r <= counter_r;
            end

            if (lo_accept_s) begin
                lo_r <= In_Byte;
            end else begin
                lo_r <= lo_r;
            end

            // Address and data are loaded as the high byte lands, so they are
            // valid during the write cycle and hold afterwards.
            if (hi_accept_s && word_legal_s) begin
                pm_addr_r  <= counter_r;
                pm_wdata_r <= InsWidth'(checked_word_s);
            end else begin
                pm_addr_r  <= pm_addr_r;
                pm_wdata_r <= pm_wdata_r;
            end
        end
    end

    // Completion pulse and sticky illegal-instruction report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_addr_r <= '0;
        end else begin
            done_r <= (start_acc_s && len_zero_s) ||
                      ((state_r == LS_WRITE) && last_word_s);

            if (start_acc_s) begin
                err_r <= 1'b0;
            end else if (hi_accept_s && !word_legal_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end

            if (hi_accept_s && !word_legal_s && !err_r) begin
                err_addr_r <= counter_r;
            end else begin
                err_addr_r <= err_addr_r;
            end
        end
    end

    assign In_Ready = in_ready_s;
    assign Busy     = busy_s;
    assign PM_WE    = pm_we_s;
    assign PM_Addr  = pm_addr_r;
    assign PM_WData = pm_wdata_r;
    assign Done     = done_r;
    assign Err      = err_r;
    assign ErrAddr  = err_addr_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a byte-stream reference model is
// compared with the DUT on every falling edge, plus directed literal checks.
`timescale 1ns/1ps
module tb_program_loader;

    localparam int AW = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          Start    = 1'b0;
    logic [AW:0]   Len      = '0;
    logic          In_Valid = 1'b0;
    logic [7:0]    In_Byte  = '0;
    logic          In_Ready;
    logic          PM_WE;
    logic [AW-1:0] PM_Addr;
    logic [12:0]   PM_WData;
    logic          Busy;
    logic          Done;
    logic          Err;
    logic [AW-1:0] ErrAddr;

    program_loader #(.PM_AW(AW), .InsWidth(13)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Len(Len),
        .In_Valid(In_Valid), .In_Byte(In_Byte), .In_Ready(In_Ready),
        .PM_WE(PM_WE), .PM_Addr(PM_Addr), .PM_WData(PM_WData),
        .Busy(Busy), .Done(Done), .Err(Err), .ErrAddr(ErrAddr)
    );

    // Stand-alone legality checker, swept against the bench's own rule.
    logic [12:0] sw_word = '0;
    logic        sw_legal;
    logic [12:0] sw_out;
    ins_checker u_ref_chk (.ins(sw_word), .legal(sw_legal), .checked_word(sw_out));

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int wlog_a[$];
    int wlog_d[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Legality of a high byte: pad bits clear and no unimplemented rest opcode.
    function automatic bit hi_ok(input int b);
        int sec  = (b >> 3) & 3;
        int rest = b & 7;
        return ((b >> 5) == 0) && !(sec == 3 && rest > 4);
    endfunction

    // ---------------- reference model (byte-stream level) ----------------
    int        m_mode    = 0;   // 0 idle, 1 loading, 2 error
    int        m_nb      = 0;   // bytes consumed in this load
    int        m_len     = 0;
    bit        m_wr      = 0;
    bit        m_done    = 0;
    bit        m_err     = 0;
    int        m_erraddr = 0;
    int        m_addr    = 0;
    int        m_data    = 0;
    int        m_lo      = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_nb = 0; m_len = 0; m_wr = 0; m_done = 0;
            m_err = 0; m_erraddr = 0; m_addr = 0; m_data = 0; m_lo = 0;
        end else begin
            m_done = 0;
            if (m_mode != 1) begin
                if (Start) begin
                    m_err = 0;
                    if (Len == 0) begin
                        m_done = 1;
                        m_mode = 0;
                    end else begin
                        m_mode = 1;
                        m_len  = int'(Len);
                        m_nb   = 0;
                        m_wr   = 0;
                    end
                end
            end else if (m_wr) begin
                m_wr = 0;
                if (m_nb == 2 * m_len) begin
                    m_mode = 0;
                    m_done = 1;
                end
            end else if (In_Valid) begin
                if (m_nb % 2 == 0) begin
                    m_lo = int'(In_Byte);
                    m_nb++;
                end else begin
                    m_nb++;
                    if (hi_ok(int'(In_Byte))) begin
                        m_wr   = 1;
                        m_addr = m_nb / 2 - 1;
                        m_data = (int'(In_Byte) & 31) * 256 + m_lo;
                    end else begin
                        m_mode    = 2;
                        m_err     = 1;
                        m_erraddr = m_nb / 2 - 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        chk("In_Ready", {31'd0, In_Ready}, {31'd0, (m_mode == 1) && !m_wr});
        chk("Busy",     {31'd0, Busy},     {31'd0, m_mode == 1});
        chk("PM_WE",    {31'd0, PM_WE},    {31'd0, m_wr});
        chk("PM_Addr",  {24'd0, PM_Addr},  m_addr);
        chk("PM_WData", {19'd0, PM_WData}, m_data);
        chk("Done",     {31'd0, Done},     {31'd0, m_done});
        chk("Err",      {31'd0, Err},      {31'd0, m_err});
        chk("ErrAddr",  {24'd0, ErrAddr},  m_erraddr);
        if (PM_WE === 1'b1) begin
            wlog_a.push_back(int'(PM_Addr));
            wlog_d.push_back(int'(PM_WData));
        end
        if (Done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int len);
        logic [31:0] l = len;
        Start = 1'b1;
        Len   = l[AW:0];
        tick();
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise);
        int gaps   = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        int budget = 64;
        bit acc    = 0;
        for (int i = 0; i < gaps; i++) begin
            In_Valid = 1'b0;
            In_Byte  = 8'($urandom_range(0, 255));
            Start    = noise && ($urandom_range(0, 3) == 0);
            Len      = 9'($urandom_range(0, 256));
            tick();
        end
        In_Valid = 1'b1;
        In_Byte  = b;
        while (!acc && budget > 0) begin
            Start = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = In_Ready;
            tick();
            budget--;
        end
        In_Valid = 1'b0;
        Start    = 1'b0;
        if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int b = 600;
        while (Busy !== 1'b0 && b > 0) begin
            tick();
            b--;
        end
        if (b == 0) chk("busy_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] rand_hi(input bit legal);
        logic [7:0] h;
        if (legal) begin
            h = 8'($urandom_range(0, 31));
            if (h[4:3] == 2'b11 && h[2:0] > 3'd4) h[2:0] = 3'($urandom_range(0, 4));
        end else if ($urandom_range(0, 1) == 1) begin
            h = {3'($urandom_range(1, 7)), 5'($urandom_range(0, 31))};
        end else begin
            h = {3'($urandom_range(0, 7)), 2'b11, 3'($urandom_range(5, 7))};
        end
        return h;
    endfunction

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int w0, d0;
    int gen[$];

    initial begin
        // Reset values, asynchronously applied before any clock edge.
        #2;
        chk("rst_In_Ready", {31'd0, In_Ready}, 32'd0);
        chk("rst_PM_WE",    {31'd0, PM_WE},    32'd0);
        chk("rst_PM_Addr",  {24'd0, PM_Addr},  32'd0);
        chk("rst_PM_WData", {19'd0, PM_WData}, 32'd0);
        chk("rst_Busy",     {31'd0, Busy},     32'd0);
        chk("rst_Done",     {31'd0, Done},     32'd0);
        chk("rst_Err",      {31'd0, Err},      32'd0);
        chk("rst_ErrAddr",  {24'd0, ErrAddr},  32'd0);

        // Legality rule for every 13-bit word.
        for (int w = 0; w < 8192; w++) begin
            sw_word = 13'(w);
            #1;
            chk("chk_legal", {31'd0, sw_legal},
                {31'd0, !((((w >> 11) & 3) == 3) && (((w >> 8) & 7) > 4))});
            chk("chk_word", {19'd0, sw_out}, w);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(); tick();

        // Two-word load.
        w0 = wlog_a.size(); d0 = done_cnt;
        start_load(2);
        send_byte(8'h2A, 0, 0); send_byte(8'h03, 0, 0);
        send_byte(8'hFF, 0, 0); send_byte(8'h18, 0, 0);
        wait_idle(); tick(); tick();
        chk("t2w_nwr",  wlog_a.size() - w0, 32'd2);
        chk("t2w_a0",   wlog_a[w0],     32'd0);
        chk("t2w_d0",   wlog_d[w0],     32'h032A);
        chk("t2w_a1",   wlog_a[w0 + 1], 32'd1);
        chk("t2w_d1",   wlog_d[w0 + 1], 32'h18FF);
        chk("t2w_done", done_cnt - d0,  32'd1);
        chk("t2w_err",  {31'd0, Err},   32'd0);

        // Illegal rest opcode in the second word.
        w0 = wlog_a.size();
        start_load(3);
        send_byte(8'h11, 0, 0); send_byte(8'h00, 0, 0);
        send_byte(8'h22, 0, 0); send_byte(8'h1D, 0, 0);
        tick();
        chk("rest5_err",   {31'd0, Err},      32'd1);
        chk("rest5_addr",  {24'd0, ErrAddr},  32'd1);
        chk("rest5_ready", {31'd0, In_Ready}, 32'd0);
        chk("rest5_busy",  {31'd0, Busy},     32'd0);
        In_Valid = 1'b1; In_Byte = 8'h5A;
        for (int i = 0; i < 4; i++) tick();
        In_Valid = 1'b0;
        chk("rest5_nwr", wlog_a.size() - w0, 32'd1);
        chk("rest5_a0",  wlog_a[w0], 32'd0);
        chk("rest5_d0",  wlog_d[w0], 32'h0011);

        // Pad bits set in the high byte, then recovery with a new load.
        w0 = wlog_a.size();
        start_load(2);
        chk("pad_err_clr", {31'd0, Err}, 32'd0);
        send_byte(8'h55, 1, 0); send_byte(8'h23, 1, 0);
        tick();
        chk("pad_err",  {31'd0, Err},     32'd1);
        chk("pad_addr", {24'd0, ErrAddr}, 32'd0);
        chk("pad_nwr",  wlog_a.size() - w0, 32'd0);
        d0 = done_cnt;
        start_load(1);
        chk("rec_err_clr", {31'd0, Err}, 32'd0);
        send_byte(8'h44, 0, 0); send_byte(8'h05, 0, 0);
        wait_idle(); tick(); tick();
        chk("rec_nwr",  wlog_a.size() - w0, 32'd1);
        chk("rec_a0",   wlog_a[w0], 32'd0);
        chk("rec_d0",   wlog_d[w0], 32'h0544);
        chk("rec_done", done_cnt - d0, 32'd1);

        // Zero-length load.
        w0 = wlog_a.size();
        start_load(0);
        chk("len0_done",  {31'd0, Done},     32'd1);
        chk("len0_ready", {31'd0, In_Ready}, 32'd0);
        chk("len0_we",    {31'd0, PM_WE},    32'd0);
        tick();
        chk("len0_done_off", {31'd0, Done}, 32'd0);
        chk("len0_nwr", wlog_a.size() - w0, 32'd0);

        // Reset between the low and high byte.
        w0 = wlog_a.size();
        start_load(4);
        send_byte(8'h77, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, In_Ready}, 32'd0);
        chk("arst_busy",  {31'd0, Busy},     32'd0);
        chk("arst_we",    {31'd0, PM_WE},    32'd0);
        chk("arst_addr",  {24'd0, PM_Addr},  32'd0);
        chk("arst_wdata", {19'd0, PM_WData}, 32'd0);
        chk("arst_done",  {31'd0, Done},     32'd0);
        chk("arst_err",   {31'd0, Err},      32'd0);
        tick();
        rst = 1'b0;
        In_Valid = 1'b1; In_Byte = 8'h01;
        tick(); tick();
        In_Valid = 1'b0;
        chk("arst_nwr", wlog_a.size() - w0, 32'd0);

        // Full-depth load with random gaps.
        w0 = wlog_a.size(); d0 = done_cnt;
        gen.delete();
        start_load(256);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo = 8'($urandom_range(0, 255));
            logic [7:0] hi = rand_hi(1'b1);
            gen.push_back(int'(hi) * 256 + int'(lo));
            send_byte(lo, 2, 1);
            send_byte(hi, 2, 1);
        end
        wait_idle(); tick(); tick();
        chk("full_nwr",  wlog_a.size() - w0, 32'd256);
        chk("full_done", done_cnt - d0, 32'd1);
        for (int i = 0; i < 256; i++) begin
            chk("full_addr", wlog_a[w0 + i], i);
            chk("full_data", wlog_d[w0 + i], gen[i]);
        end

        // Random loads with occasional illegal words and stray Start pulses.
        for (int t = 0; t < 25; t++) begin
            int len = int'($urandom_range(0, 6));
            start_load(len);
            for (int i = 0; i < len; i++) begin
                bit ok = ($urandom_range(0, 7) != 0);
                send_byte(8'($urandom_range(0, 255)), 3, 1);
                send_byte(rand_hi(ok), 3, 1);
                if (!ok) break;
            end
            wait_idle();
            tick();
        end

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
